pipe_reg_2read_port: RTL and testbench
======================================

Name: pipe_reg_2read_port

Overview:
- Read-side counterpart of the two-write-port pipe register: one write stream in, two read ports out.
- Small in-order FIFO stage, DEPTH entries, presenting the two oldest entries at the same time.
- Port 0 always holds the oldest entry and port 1 the next oldest, so a consumer can pop one or two words per cycle.
- Sits between a single-word producer and a dual-issue consumer; provides full/empty status and sticky error flags.

Parameters:
- DSIZE, 8, data width in bits.
- DEPTH, 4, number of storage entries; power of two, minimum 2.
- ASIZE, 2, pointer width; must equal log2(DEPTH).

Ports:
- clock     input   1          rising-edge clock
- rst       input   1          reset, asynchronous, active-high
- wr_en     input   1          write request
- indata    input   DSIZE      write data
- rd_en0    input   1          pop oldest entry (port 0)
- rd_en1    input   1          pop second entry (port 1); only legal together with rd_en0
- valid0    output  1          port 0 holds data (count >= 1)
- valid1    output  1          port 1 holds data (count >= 2)
- outdata0  output  DSIZE      oldest entry; 0 when valid0 = 0
- outdata1  output  DSIZE      second-oldest entry; 0 when valid1 = 0
- full      output  1          count == DEPTH
- empty     output  1          count == 0
- count     output  ASIZE+1    entries held, 0..DEPTH
- ovf_err   output  1          sticky: a write was dropped
- udf_err   output  1          sticky: an illegal read was dropped

Behaviour:
- Reset (asynchronous, active-high):
  - rd_ptr, wr_ptr, count, ovf_err and udf_err clear to 0; storage clears to 0.
  - Outputs while in reset: valid0 = valid1 = 0, empty = 1, full = 0, outdata0 = outdata1 = 0.
  - Reset mid-operation discards all contents immediately, without waiting for a clock edge.
- Pop resolution (combinational, from the current registered count):
  - pop0 = rd_en0 and count >= 1.
  - pop1 = rd_en1 and rd_en0 and count >= 2.
  - npop = pop0 + pop1.
- Illegal reads set udf_err and are ignored (no pointer or count change):
  - rd_en0 with count == 0.
  - rd_en1 without rd_en0.
  - rd_en1 with count < 2.
  - A legal pop0 in the same cycle still proceeds.
- Write acceptance:
  - push = wr_en and (count - npop) < DEPTH.
  - A write while full is accepted if a pop occurs in the same cycle.
  - wr_en with no free slot after pops: data dropped, ovf_err set.
- Write data path:
  - Data lands in mem[wr_ptr].
  - wr_ptr increments mod DEPTH.
  - count_next = count + push - npop.
- Read pointer: rd_ptr advances by npop mod DEPTH; wrap-around is natural pointer overflow.
- Output data:
  - outdata0 = mem[rd_ptr].
  - outdata1 = mem[rd_ptr+1 mod DEPTH].
  - Both are combinational from registered state, masked to 0 when their valid is low.
- Latency:
  - A word written at edge N is visible on valid0/outdata0 after edge N; there is no write-to-read bypass in the same cycle.
  - Pops take effect at the clock edge.
- Into-empty write with simultaneous read: when count == 0, wr_en together with rd_en0 pushes the word and flags udf_err (no bypass).
- full, empty and count are derived from registered count only.
- Error flags: ovf_err and udf_err stay set until rst.
- Ordering: FIFO order is preserved across ports; port 1 data never leaves before port 0 data.

Test Plan:
- Reset, then write 0xA1 at edge 1 -> after edge 1: valid0 = 1, outdata0 = 0xA1, valid1 = 0, outdata1 = 0, count = 1.
- Write 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> full = 1, count = 4. Fifth write 0x55 -> dropped, ovf_err = 1, contents unchanged.
- From full, rd_en0 = rd_en1 = 1 with wr_en = 1, indata = 0x66 -> next: count = 3, outdata0 = 0x33, outdata1 = 0x44.
- Wrap-around: stream 10 writes 0x00..0x09 while dual-popping every other cycle -> port pairs read out in order (0x00,0x01), (0x02,0x03), ...; no errors.
- rd_en1 alone with count = 2 -> no pop, udf_err = 1, count = 2. rd_en0 on empty -> udf_err = 1, count stays 0.
- Assert rst mid-stream with count = 3, between clock edges -> valid0, valid1 and count drop to 0 and empty = 1 before the next edge. After release, the first write behaves as in scenario 1.

Source files
------------

// File: rtl/pipe_reg_2read_port.sv
// rtl/pipe_reg_2read_port.sv - in-order FIFO stage exposing the two oldest entries on two read ports
module pipe_reg_2read_port #(
    parameter int DSIZE = 8,
    parameter int DEPTH = 4,
    parameter int ASIZE = 2
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [DSIZE-1:0] indata,
    input  logic             rd_en0,
    input  logic             rd_en1,
    output logic             valid0,
    output logic             valid1,
    output logic [DSIZE-1:0] outdata0,
    output logic [DSIZE-1:0] outdata1,
    output logic             full,
    output logic             empty,
    output logic [ASIZE:0]   count,
    output logic             ovf_err,
    output logic             udf_err
);

    logic [DSIZE-1:0] mem_q [DEPTH];
    logic [ASIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic [ASIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [ASIZE:0]   count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic             pop0, pop1, push, rd_illegal;
    logic [1:0]       npop;
    logic [ASIZE:0]   count_after_pop;
    logic [ASIZE-1:0] rd_ptr1;

    assign valid0  = (count_q != '0);
    assign valid1  = (count_q >= (ASIZE+1)'(2));
    assign full    = (count_q == (ASIZE+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign ovf_err = ovf_q;
    assign udf_err = udf_q;

    // Pops are resolved against the registered count; a write never bypasses to a read port.
    always_comb begin
        pop0            = rd_en0 && valid0;
        pop1            = rd_en1 && rd_en0 && valid1;
        npop            = {1'b0, pop0} + {1'b0, pop1};
        rd_illegal      = (rd_en0 && !valid0) || (rd_en1 && !rd_en0) || (rd_en1 && !valid1);
        count_after_pop = count_q - (ASIZE+1)'(npop);
        push            = wr_en && (count_after_pop < (ASIZE+1)'(DEPTH));

        rd_ptr_d = rd_ptr_q + ASIZE'(npop);
        wr_ptr_d = push ? wr_ptr_q + ASIZE'(1) : wr_ptr_q;
        count_d  = count_after_pop + (ASIZE+1)'(push);
        ovf_d    = ovf_q || (wr_en && !push);
        udf_d    = udf_q || rd_illegal;
    end

    assign rd_ptr1  = rd_ptr_q + ASIZE'(1);
    assign outdata0 = valid0 ? mem_q[rd_ptr_q] : '0;
    assign outdata1 = valid1 ? mem_q[rd_ptr1]  : '0;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= indata;
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

endmodule

// File: tb/tb_pipe_reg_2read_port.sv
// tb/tb_pipe_reg_2read_port.sv - self-checking bench for pipe_reg_2read_port
module tb_pipe_reg_2read_port;

    localparam int DSIZE = 8;
    localparam int DEPTH = 4;
    localparam int ASIZE = 2;

    logic             clock = 1'b0;
    logic             rst   = 1'b1;
    logic             wr_en = 1'b0;
    logic [DSIZE-1:0] indata = '0;
    logic             rd_en0 = 1'b0;
    logic             rd_en1 = 1'b0;
    logic             valid0, valid1, full, empty, ovf_err, udf_err;
    logic [DSIZE-1:0] outdata0, outdata1;
    logic [ASIZE:0]   count;

    int tests  = 0;
    int failed = 0;

    pipe_reg_2read_port #(.DSIZE(DSIZE), .DEPTH(DEPTH), .ASIZE(ASIZE)) dut (
        .clock    (clock),
        .rst      (rst),
        .wr_en    (wr_en),
        .indata   (indata),
        .rd_en0   (rd_en0),
        .rd_en1   (rd_en1),
        .valid0   (valid0),
        .valid1   (valid1),
        .outdata0 (outdata0),
        .outdata1 (outdata1),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .ovf_err  (ovf_err),
        .udf_err  (udf_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       wr;
        logic [7:0] din;
        logic       r0;
        logic       r1;
        int         cnt;
        logic [7:0] o0;
        logic [7:0] o1;
        logic       ovf;
        logic       udf;
    } vec_t;

    vec_t vecs [14];

    // Reference model: a plain queue of held words plus the two sticky flags.
    logic [7:0] mq [$];
    logic       m_ovf, m_udf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int cnt, input logic [7:0] o0, input logic [7:0] o1,
                           input logic ovf, input logic udf);
        chk({tag, ".count"},    32'(count),    32'(cnt));
        chk({tag, ".valid0"},   32'(valid0),   32'(cnt >= 1));
        chk({tag, ".valid1"},   32'(valid1),   32'(cnt >= 2));
        chk({tag, ".full"},     32'(full),     32'(cnt == DEPTH));
        chk({tag, ".empty"},    32'(empty),    32'(cnt == 0));
        chk({tag, ".outdata0"}, 32'(outdata0), 32'(o0));
        chk({tag, ".outdata1"}, 32'(outdata1), 32'(o1));
        chk({tag, ".ovf_err"},  32'(ovf_err),  32'(ovf));
        chk({tag, ".udf_err"},  32'(udf_err),  32'(udf));
    endtask

    task automatic drive(input logic w, input logic [7:0] d, input logic r0, input logic r1);
        wr_en = w; indata = d; rd_en0 = r0; rd_en1 = r1;
    endtask

    // Inputs change at the falling edge; outputs are sampled at the next falling edge.
    task automatic cycle(input logic w, input logic [7:0] d, input logic r0, input logic r1);
        drive(w, d, r0, r1);
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk_all("reset", 0, 8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clock);
        rst = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    task automatic model_step(input logic w, input logic [7:0] d, input logic r0, input logic r1);
        int n;
        n = mq.size();
        if ((r0 && n == 0) || (r1 && !(r0 && n >= 2))) m_udf = 1'b1;
        if (r0 && n >= 1) void'(mq.pop_front());
        if (r1 && r0 && n >= 2) void'(mq.pop_front());
        if (w) begin
            if (mq.size() < DEPTH) mq.push_back(d);
            else m_ovf = 1'b1;
        end
    endtask

    initial begin
        logic       w, r0, r1;
        logic [7:0] d, e0, e1;

        vecs[0]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1, 8'hA1, 8'h00, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1, 8'h11, 8'h00, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 8'h22, 1'b0, 1'b0, 2, 8'h11, 8'h22, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 8'h33, 1'b0, 1'b0, 3, 8'h11, 8'h22, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 8'h44, 1'b0, 1'b0, 4, 8'h11, 8'h22, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 8'h55, 1'b0, 1'b0, 4, 8'h11, 8'h22, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 8'h66, 1'b1, 1'b1, 3, 8'h33, 8'h44, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1, 8'h66, 8'h00, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 8'h77, 1'b0, 1'b0, 2, 8'h66, 8'h77, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 2, 8'h66, 8'h77, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 8'h00, 8'h00, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h00, 8'h00, 1'b1, 1'b1};
        vecs[13] = '{1'b1, 8'h88, 1'b1, 1'b0, 1, 8'h88, 8'h00, 1'b1, 1'b1};

        do_reset();
        for (int i = 0; i < 14; i++) begin
            cycle(vecs[i].wr, vecs[i].din, vecs[i].r0, vecs[i].r1);
            chk_all($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].o0, vecs[i].o1, vecs[i].ovf, vecs[i].udf);
        end

        // Read on empty sets udf without moving count.
        do_reset();
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk_all("rd_empty", 0, 8'h00, 8'h00, 1'b0, 1'b1);

        // Dual pop with only one entry: pop0 proceeds, udf flagged.
        do_reset();
        cycle(1'b1, 8'h5A, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        chk_all("dual_on_one", 0, 8'h00, 8'h00, 1'b0, 1'b1);

        // Wrap-around streaming with a dual pop every other cycle.
        do_reset();
        for (int i = 0; i <= 10; i++) begin
            if (i >= 2 && i % 2 == 0) begin
                chk($sformatf("wrap%0d.out0", i), 32'(outdata0), 32'(i - 2));
                chk($sformatf("wrap%0d.out1", i), 32'(outdata1), 32'(i - 1));
            end
            cycle(i < 10, 8'(i), (i >= 2 && i % 2 == 0), (i >= 2 && i % 2 == 0));
        end
        chk_all("wrap_end", 0, 8'h00, 8'h00, 1'b0, 1'b0);

        // Randomised run against the queue model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            w  = 1'($urandom_range(0, 99) < 60);
            d  = 8'($urandom);
            r0 = 1'($urandom_range(0, 99) < 50);
            r1 = r0 ? 1'($urandom_range(0, 99) < 50) : 1'($urandom_range(0, 99) < 3);
            model_step(w, d, r0, r1);
            cycle(w, d, r0, r1);
            e0 = (mq.size() >= 1) ? mq[0] : 8'h00;
            e1 = (mq.size() >= 2) ? mq[1] : 8'h00;
            chk_all($sformatf("rnd%0d", i), mq.size(), e0, e1, m_ovf, m_udf);
            if (i % 100 == 99) do_reset();
        end

        // Asynchronous reset between edges with three entries held.
        do_reset();
        cycle(1'b1, 8'h01, 1'b0, 1'b0);
        cycle(1'b1, 8'h02, 1'b0, 1'b0);
        cycle(1'b1, 8'h03, 1'b0, 1'b0);
        chk("pre_rst.count", 32'(count), 32'd3);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        @(posedge clock);
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 0, 8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clock);
        rst = 1'b0;
        cycle(1'b1, 8'hA1, 1'b0, 1'b0);
        chk_all("post_rst", 1, 8'hA1, 8'h00, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
